// File: rtl/seq_addsub_alu.sv
// Multi-cycle ADD/SUB/AND/XOR unit: one W-bit slice per clock with a registered carry, Y86 flags.
// Accept on edge E, out_valid after edge E+K; held until out_ready, no new op taken until then.
module seq_addsub_alu #(
  parameter int N = 64,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zf,
  output logic         sf,
  output logic         of,
  output logic         cf
);

  localparam int K  = N / W;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  logic [1:0]    state;
  logic [N-1:0]  a_q, b_q;
  logic [1:0]    op_q;
  logic          carry;
  logic          zacc;
  logic [IW-1:0] idx;

  logic [W-1:0]  a_sl, b_sl, b_inv, slice;
  logic [W:0]    sum;
  logic          arith, last, cin_msb;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_comb begin
    a_sl    = a_q[idx*W +: W];
    b_sl    = b_q[idx*W +: W];
    arith   = ~op_q[1];
    b_inv   = b_sl ^ {W{op_q == OP_SUB}};
    sum     = {1'b0, a_sl} + {1'b0, b_inv} + {{W{1'b0}}, carry};
    // carry into the slice MSB, recovered from the sum bit for the overflow flag
    cin_msb = a_sl[W-1] ^ b_inv[W-1] ^ sum[W-1];
    last    = (idx == IW'(K - 1));
    if (arith)
      slice = sum[W-1:0];
    else if (op_q == OP_AND)
      slice = a_sl & b_sl;
    else
      slice = a_sl ^ b_sl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      carry  <= 1'b0;
      zacc   <= 1'b0;
      idx    <= '0;
      result <= '0;
      zf     <= 1'b0;
      sf     <= 1'b0;
      of     <= 1'b0;
      cf     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            carry <= (op == OP_SUB);
            idx   <= '0;
            zacc  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          result[idx*W +: W] <= slice;
          if (arith)
            carry <= sum[W];
          zacc <= zacc & (slice == '0);
          if (last) begin
            zf    <= zacc & (slice == '0);
            sf    <= slice[W-1];
            of    <= arith & (cin_msb ^ sum[W]);
            cf    <= arith & sum[W];
            state <= S_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_DONE: begin
          if (out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_addsub_alu.sv
// Directed bench for seq_addsub_alu: three instances (W=16, 64, 8) driven in lockstep from a vector table,
// plus backpressure and mid-RUN reset sequences.
module tb_seq_addsub_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [63:0] a = '0;
  logic [63:0] b = '0;

  logic [2:0]  in_ready, out_valid, zf, sf, of, cf;
  logic [63:0] res [3];

  localparam int KS [3] = '{4, 1, 8};

  int n_chk  = 0;
  int n_fail = 0;
  int lat [3];

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [3:0]  flags; // {zf, sf, of, cf}
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  seq_addsub_alu #(.N(64), .W(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]), .op(op), .a(a), .b(b),
    .out_valid(out_valid[0]), .out_ready(out_ready), .result(res[0]),
    .zf(zf[0]), .sf(sf[0]), .of(of[0]), .cf(cf[0]));

  seq_addsub_alu #(.N(64), .W(64)) u_w64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]), .op(op), .a(a), .b(b),
    .out_valid(out_valid[1]), .out_ready(out_ready), .result(res[1]),
    .zf(zf[1]), .sf(sf[1]), .of(of[1]), .cf(cf[1]));

  seq_addsub_alu #(.N(64), .W(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]), .op(op), .a(a), .b(b),
    .out_valid(out_valid[2]), .out_ready(out_ready), .result(res[2]),
    .zf(zf[2]), .sf(sf[2]), .of(of[2]), .cf(cf[2]));

  task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %h expected %h", name, inst, act, exp);
    end
  endtask

  task automatic chk_idle_reset(input string name);
    for (int i = 0; i < 3; i++) begin
      chk({name, "_in_ready"}, i, 64'(in_ready[i]), 64'd1);
      chk({name, "_out_valid"}, i, 64'(out_valid[i]), 64'd0);
      chk({name, "_result"}, i, res[i], 64'd0);
      chk({name, "_flags"}, i, 64'({zf[i], sf[i], of[i], cf[i]}), 64'd0);
    end
  endtask

  // Present an op for one accept edge, scramble the inputs, then measure per-instance latency.
  task automatic issue(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("pre_in_ready", i, 64'(in_ready[i]), 64'd1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = ~o;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) lat[i] = 0;
    for (int c = 1; c <= 20 && !(lat[0] != 0 && lat[1] != 0 && lat[2] != 0); c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++)
        if (out_valid[i] && lat[i] == 0) lat[i] = c;
    end
    for (int i = 0; i < 3; i++) chk("latency", i, 64'(lat[i]), 64'(KS[i]));
  endtask

  task automatic check_out(input vec_t v);
    for (int i = 0; i < 3; i++) begin
      chk("result", i, res[i], v.res);
      chk("flags_zsoc", i, 64'({zf[i], sf[i], of[i], cf[i]}), 64'(v.flags));
    end
  endtask

  task automatic complete();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_hs_out_valid", i, 64'(out_valid[i]), 64'd0);
      chk("post_hs_in_ready", i, 64'(in_ready[i]), 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs[0] = '{2'b00, 64'h0000_0000_0000_FFFF, 64'h1,                  64'h0000_0000_0001_0000, 4'b0000};
    vecs[1] = '{2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1,                  64'h8000_0000_0000_0000, 4'b0110};
    vecs[2] = '{2'b01, 64'h5,                   64'h5,                  64'h0,                   4'b1001};
    vecs[3] = '{2'b01, 64'h8000_0000_0000_0000, 64'h1,                  64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
    vecs[4] = '{2'b11, 64'hFFFF_0000_FFFF_0000, 64'hFFFF_0000_FFFF_0000, 64'h0,                  4'b1000};
    vecs[5] = '{2'b10, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hF000_F000_F000_F000, 4'b0100};
    vecs[6] = '{2'b01, 64'h0,                   64'h1,                  64'hFFFF_FFFF_FFFF_FFFF, 4'b0100};
    vecs[7] = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                  64'h0,                   4'b1001};
    vecs[8] = '{2'b11, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_0000_0000, 64'hFEDC_BA98_89AB_CDEF, 4'b0100};

    repeat (3) @(posedge clk);
    #1;
    chk_idle_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 9; t++) begin
      issue(vecs[t].op, vecs[t].a, vecs[t].b);
      check_out(vecs[t]);
      complete();
    end

    // Backpressure: outputs frozen, new in_valid ignored while DONE.
    v = '{2'b00, 64'h1234, 64'h1111, 64'h2345, 4'b0000};
    issue(v.op, v.a, v.b);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = (c == 1);
      op = 2'b01; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        chk("bp_out_valid", i, 64'(out_valid[i]), 64'd1);
        chk("bp_in_ready", i, 64'(in_ready[i]), 64'd0);
      end
      check_out(v);
    end
    complete();
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_not_captured", i, 64'(out_valid[i]), 64'd0);
      chk("bp_result_held", i, res[i], 64'h2345);
    end

    // Asynchronous reset two edges into RUN.
    @(negedge clk);
    op = 2'b00; a = 64'h1111_1111_1111_1111; b = 64'h2222_2222_2222_2222; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_reset("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    v = '{2'b00, 64'h3, 64'h4, 64'h7, 4'b0000};
    issue(v.op, v.a, v.b);
    check_out(v);
    complete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
